// File: rtl/multi_digit_display_mux.sv
// Time-multiplexed seven-segment driver for NUM_DIGITS hex digits.
// It captures a frame snapshot with its sum, then scans the digits with a dwell phase and a dead phase.

module mddm_hex_dec (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    // active-low gfedcba
    always_comb begin
        seg_o = 7'h7F;
        case (nib_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'h7F;
        endcase
    end
endmodule

module multi_digit_display_mux #(
    parameter int NUM_DIGITS = 2,
    parameter int DWELL      = 4096,
    parameter int DEAD       = 16,
    parameter int SUM_W      = 4 + $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digit_values,
    input  logic                    blank_leading,
    output logic [NUM_DIGITS-1:0]   display_select,
    output logic [6:0]              display,
    output logic [SUM_W-1:0]        sum,
    output logic                    frame_start
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CMAX  = (DWELL > DEAD) ? DWELL : DEAD;
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] DEAD_END  = CNT_W'((DEAD > 0) ? DEAD - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_DEAD} state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d, nxt_idx;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0]   snap_q;
    logic [NUM_DIGITS-1:0]        blank_q, blank_d;
    logic [SUM_W-1:0]             sum_q, sum_d;
    logic                         fs_q;
    logic                         capture;
    logic                         zero_run;
    logic [NUM_DIGITS-1:0][6:0]   seg_all;

    assign nxt_idx = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_SHOW;
                idx_d   = '0;
                cnt_d   = '0;
                capture = 1'b1;
            end
            ST_SHOW: begin
                if (cnt_q == DWELL_END) begin
                    cnt_d = '0;
                    if (DEAD == 0) begin
                        idx_d   = nxt_idx;
                        capture = (nxt_idx == '0);
                    end else begin
                        state_d = ST_DEAD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DEAD: begin
                if (cnt_q == DEAD_END) begin
                    state_d = ST_SHOW;
                    idx_d   = nxt_idx;
                    cnt_d   = '0;
                    capture = (nxt_idx == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sum and blank mask are computed from the live inputs so the capture edge latches them with the snapshot.
    always_comb begin
        sum_d    = '0;
        blank_d  = '0;
        zero_run = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++)
            sum_d = sum_d + SUM_W'(digit_values[4*k +: 4]);
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run & (digit_values[4*k +: 4] == 4'h0);
            blank_d[k] = blank_leading & zero_run;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            blank_q <= '0;
            sum_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fs_q    <= capture;
            if (capture) begin
                snap_q  <= digit_values;
                blank_q <= blank_d;
                sum_q   <= sum_d;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        mddm_hex_dec u_dec (
            .nib_i (snap_q[g]),
            .seg_o (seg_all[g])
        );
    end

    // Outputs depend only on registered state, so an async reset blanks them immediately.
    always_comb begin
        display_select = '1;
        display        = 7'h7F;
        if (state_q == ST_SHOW) begin
            display_select[idx_q] = 1'b0;
            if (!blank_q[idx_q])
                display = seg_all[idx_q];
        end
    end

    assign sum         = sum_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_multi_digit_display_mux.sv
// Directed bench for multi_digit_display_mux across four parameter sets.
module tb_multi_digit_display_mux;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A: 2 digits, DWELL 4, DEAD 1
    logic       rst_a = 1'b1, bl_a = 1'b0;
    logic [7:0] dv_a = 8'h53;
    logic [1:0] sel_a; logic [6:0] disp_a; logic [4:0] sum_a; logic fs_a;
    multi_digit_display_mux #(.NUM_DIGITS(2), .DWELL(4), .DEAD(1)) u_a (
        .clk(clk), .reset(rst_a), .digit_values(dv_a), .blank_leading(bl_a),
        .display_select(sel_a), .display(disp_a), .sum(sum_a), .frame_start(fs_a));

    // B: 4 digits, DWELL 2, DEAD 0
    logic        rst_b = 1'b1, bl_b = 1'b0;
    logic [15:0] dv_b = 16'hFFFF;
    logic [3:0]  sel_b; logic [6:0] disp_b; logic [5:0] sum_b; logic fs_b;
    multi_digit_display_mux #(.NUM_DIGITS(4), .DWELL(2), .DEAD(0)) u_b (
        .clk(clk), .reset(rst_b), .digit_values(dv_b), .blank_leading(bl_b),
        .display_select(sel_b), .display(disp_b), .sum(sum_b), .frame_start(fs_b));

    // C: 3 digits, DWELL 5, DEAD 2
    logic        rst_c = 1'b1, bl_c = 1'b0;
    logic [11:0] dv_c = 12'h123;
    logic [2:0]  sel_c; logic [6:0] disp_c; logic [5:0] sum_c; logic fs_c;
    multi_digit_display_mux #(.NUM_DIGITS(3), .DWELL(5), .DEAD(2)) u_c (
        .clk(clk), .reset(rst_c), .digit_values(dv_c), .blank_leading(bl_c),
        .display_select(sel_c), .display(disp_c), .sum(sum_c), .frame_start(fs_c));

    // D: 1 digit, DWELL 1, DEAD 0
    logic       rst_d = 1'b1, bl_d = 1'b0;
    logic [3:0] dv_d = 4'h0;
    logic [0:0] sel_d; logic [6:0] disp_d; logic [3:0] sum_d; logic fs_d;
    multi_digit_display_mux #(.NUM_DIGITS(1), .DWELL(1), .DEAD(0)) u_d (
        .clk(clk), .reset(rst_d), .digit_values(dv_d), .blank_leading(bl_d),
        .display_select(sel_d), .display(disp_d), .sum(sum_d), .frame_start(fs_d));

    always @(negedge clk) begin
        assert ($countones(~sel_c) <= 1) else $error("one-hot violated on C: %b", sel_c);
    end

    typedef struct {
        logic [3:0] d;
        logic [6:0] seg;
    } vec_t;

    initial begin
        vec_t       tbl[16];
        logic [1:0] a_sel[11];
        logic [6:0] a_seg[11];
        logic [3:0] b_sel[8];
        logic [6:0] b_seg70[8];
        int         run[3];
        int         last_fs, fs_cnt;

        tbl[0]  = '{4'h0, 7'b1000000}; tbl[1]  = '{4'h1, 7'b1111001};
        tbl[2]  = '{4'h2, 7'b0100100}; tbl[3]  = '{4'h3, 7'b0110000};
        tbl[4]  = '{4'h4, 7'b0011001}; tbl[5]  = '{4'h5, 7'b0010010};
        tbl[6]  = '{4'h6, 7'b0000010}; tbl[7]  = '{4'h7, 7'b1111000};
        tbl[8]  = '{4'h8, 7'b0000000}; tbl[9]  = '{4'h9, 7'b0010000};
        tbl[10] = '{4'hA, 7'b0001000}; tbl[11] = '{4'hB, 7'b0000011};
        tbl[12] = '{4'hC, 7'b1000110}; tbl[13] = '{4'hD, 7'b0100001};
        tbl[14] = '{4'hE, 7'b0000110}; tbl[15] = '{4'hF, 7'b0001110};

        a_sel = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10};
        a_seg = '{7'h30, 7'h30, 7'h30, 7'h30, 7'h7F, 7'h12, 7'h12, 7'h12, 7'h12, 7'h7F, 7'h30};
        b_sel   = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
        b_seg70 = '{7'h40, 7'h40, 7'h78, 7'h78, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

        // reset held three cycles
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(sel_a), 32'h3);
        check("rst_disp", 32'(disp_a), 32'h7F);
        check("rst_sum", 32'(sum_a), 32'h0);
        check("rst_fs", 32'(fs_a), 32'h0);

        // ---- A: first frame ----
        rst_a = 1'b0;
        for (int n = 0; n < 11; n++) begin
            @(negedge clk);
            check($sformatf("a_sel[%0d]", n), 32'(sel_a), 32'(a_sel[n]));
            check($sformatf("a_disp[%0d]", n), 32'(disp_a), 32'(a_seg[n]));
            check($sformatf("a_fs[%0d]", n), 32'(fs_a), (n == 0 || n == 10) ? 32'h1 : 32'h0);
            check($sformatf("a_sum[%0d]", n), 32'(sum_a), 32'd8);
        end
        // now at frame-relative n=10; advance to digit 1 SHOW (n=16)
        repeat (6) @(negedge clk);
        check("a_pre_rst_sel", 32'(sel_a), 32'h1);
        @(posedge clk);
        #2 rst_a = 1'b1;
        #1;
        check("a_async_sel", 32'(sel_a), 32'h3);
        check("a_async_disp", 32'(disp_a), 32'h7F);
        check("a_async_sum", 32'(sum_a), 32'h0);
        @(negedge clk);
        dv_a  = 8'h21;
        rst_a = 1'b0;
        @(negedge clk);
        check("a_recap_fs", 32'(fs_a), 32'h1);
        check("a_recap_sum", 32'(sum_a), 32'd3);
        check("a_recap_sel", 32'(sel_a), 32'h2);
        check("a_recap_disp", 32'(disp_a), 32'h79);

        // ---- B: sum width, mid-frame input change, blanking ----
        rst_b = 1'b0;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (n < 8) check($sformatf("b_sum60[%0d]", n), 32'(sum_b), 32'd60);
            if (n == 0 || n == 8 || n == 16 || n == 24)
                check($sformatf("b_fs[%0d]", n), 32'(fs_b), 32'h1);
            if (n == 3) check("b_fs_mid", 32'(fs_b), 32'h0);
            if (n == 8) check("b_sum1", 32'(sum_b), 32'd1);
            if (n >= 16 && n < 24) begin
                check($sformatf("b_bl_sel[%0d]", n), 32'(sel_b), 32'(b_sel[n-16]));
                check($sformatf("b_bl_disp[%0d]", n), 32'(disp_b), 32'(b_seg70[n-16]));
            end
            if (n >= 24) begin
                check($sformatf("b_z_sel[%0d]", n), 32'(sel_b), 32'(b_sel[n-24]));
                check($sformatf("b_z_disp[%0d]", n), 32'(disp_b), (n < 26) ? 32'h40 : 32'h7F);
            end
            if (n == 2) dv_b = 16'h0001;
            if (n == 8) begin bl_b = 1'b1; dv_b = 16'h0070; end
            if (n == 16) dv_b = 16'h0000;
        end

        // ---- C: frame period and dwell lengths ----
        rst_c   = 1'b0;
        run     = '{0, 0, 0};
        last_fs = -1;
        fs_cnt  = 0;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            check("c_onehot", ($countones(~sel_c) <= 1) ? 32'h1 : 32'h0, 32'h1);
            if (fs_c) begin
                if (last_fs >= 0) check("c_period", 32'(n - last_fs), 32'd21);
                last_fs = n;
                fs_cnt++;
            end
            for (int k = 0; k < 3; k++) begin
                if (!sel_c[k]) run[k]++;
                else if (run[k] > 0) begin
                    check($sformatf("c_dwell%0d", k), 32'(run[k]), 32'd5);
                    run[k] = 0;
                end
            end
        end
        check("c_fs_count", 32'(fs_cnt), 32'd4);
        check("c_sum", 32'(sum_c), 32'd6);

        // ---- D: decode sweep ----
        rst_d = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dv_d = tbl[i].d;
            @(negedge clk);
            check($sformatf("d_seg[%0d]", i), 32'(disp_d), 32'(tbl[i].seg));
            check($sformatf("d_sum[%0d]", i), 32'(sum_d), 32'(tbl[i].d));
            check($sformatf("d_sel[%0d]", i), 32'(sel_d), 32'h0);
            check($sformatf("d_fs[%0d]", i), 32'(fs_d), 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
